// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-channel round-robin mux arbiter.
//   NUM_CH / SEL_W : channel count and select width
//   state_e        : arbiter FSM state encoding
//   CH_A..CH_D     : channel codes, equal to the mux select value {s1,s2}
//   ch_onehot()    : channel code to one-hot request/grant mask
package mux_arb_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [SEL_W-1:0] CH_A = 2'd0;
    localparam logic [SEL_W-1:0] CH_B = 2'd1;
    localparam logic [SEL_W-1:0] CH_C = 2'd2;
    localparam logic [SEL_W-1:0] CH_D = 2'd3;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant and output-handshake bundle of the mux arbiter.
//   req        : channel requests, bit0=a .. bit3=d
//   out_ready  : consumer accepts the current mux output
//   s1, s2     : mux select, {s1,s2} = granted channel code
//   gnt        : one-hot grant, zero when idle
//   out_valid  : mux output carries a granted channel's data
//   burst_last : current transfer ends the burst
// master = arbiter side, slave = requesters/consumer side.
interface mux4_rr_arbiter_if;
    import mux_arb_pkg::*;

    logic [NUM_CH-1:0] req;
    logic              out_ready;
    logic              s1;
    logic              s2;
    logic [NUM_CH-1:0] gnt;
    logic              out_valid;
    logic              burst_last;

    modport master (
        input  req, out_ready,
        output s1, s2, gnt, out_valid, burst_last
    );

    modport slave (
        output req, out_ready,
        input  s1, s2, gnt, out_valid, burst_last
    );

endinterface

// File: rtl/rr_pick4.sv
// Rotating-priority picker: returns the first set req bit searching from ptr
// upward with wrap 3->0.
//   req : candidate requests
//   ptr : highest-priority channel
//   idx : winning channel (0 when none)
//   any : at least one request set
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            logic [SEL_W-1:0] c;
            // 2-bit add wraps naturally
            c = ptr + SEL_W'(i);
            if (!any && req[c]) begin
                idx = c;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a 4:1 data mux.
// Holds a grant across the valid/ready handshake, limits each grant to
// MAX_BURST accepted transfers and hands off back-to-back when others wait.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : request/grant/handshake bundle (master side)
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input logic               clk,
    input logic               rst_n,
    mux4_rr_arbiter_if.master bus
);

    localparam logic [4:0] BurstLim = 5'(MAX_BURST);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  cur_q, cur_d;
    logic [3:0]        bcnt_q, bcnt_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              valid_q, valid_d;

    logic [SEL_W-1:0]  pick_idx, hand_idx;
    logic              pick_any, hand_any;
    logic [4:0]        bcnt_inc;
    logic              xfer;
    logic              burst_more;

    // Initial pick from IDLE uses the stored pointer.
    rr_pick4 u_pick_init (
        .req (bus.req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Hand-off pick excludes the current owner and starts after it.
    rr_pick4 u_pick_hand (
        .req (bus.req & ~ch_onehot(cur_q)),
        .ptr (cur_q + 2'd1),
        .idx (hand_idx),
        .any (hand_any)
    );

    assign bcnt_inc   = {1'b0, bcnt_q} + 5'd1;
    assign xfer       = valid_q && bus.out_ready;
    assign burst_more = bus.req[cur_q] && (bcnt_inc < BurstLim);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        bcnt_d  = bcnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    cur_d   = pick_idx;
                    sel_d   = pick_idx;
                    gnt_d   = ch_onehot(pick_idx);
                    valid_d = 1'b1;
                    bcnt_d  = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    if (burst_more) begin
                        bcnt_d = bcnt_q + 4'd1;
                    end else begin
                        ptr_d = cur_q + 2'd1;
                        if (hand_any) begin
                            cur_d  = hand_idx;
                            sel_d  = hand_idx;
                            gnt_d  = ch_onehot(hand_idx);
                            bcnt_d = '0;
                        end else if (bus.req[cur_q]) begin
                            // Sole requester: fresh burst, selects untouched.
                            bcnt_d = '0;
                        end else begin
                            // Selects keep their last value while idle.
                            state_d = IDLE;
                            gnt_d   = '0;
                            valid_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= CH_A;
            cur_q   <= CH_A;
            bcnt_q  <= '0;
            gnt_q   <= '0;
            sel_q   <= CH_A;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            bcnt_q  <= bcnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.s1         = sel_q[1];
    assign bus.s2         = sel_q[0];
    assign bus.out_valid  = valid_q;
    assign bus.burst_last = (state_q == GRANT) &&
                            ((bcnt_inc == BurstLim) || !bus.req[cur_q]);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: three instances (MAX_BURST 4, 1, 2)
// sharing clock and reset; each scenario task checks {gnt,s1,s2,valid,last}.
module tb_mux4_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if b4 ();
    mux4_rr_arbiter_if b1 ();
    mux4_rr_arbiter_if b2 ();

    mux4_rr_arbiter #(.MAX_BURST(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    mux4_rr_arbiter #(.MAX_BURST(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mux4_rr_arbiter #(.MAX_BURST(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] obs(input int which);
        case (which)
            1:       return {b1.gnt, b1.s1, b1.s2, b1.out_valid, b1.burst_last};
            2:       return {b2.gnt, b2.s1, b2.s2, b2.out_valid, b2.burst_last};
            default: return {b4.gnt, b4.s1, b4.s2, b4.out_valid, b4.burst_last};
        endcase
    endfunction

    function automatic logic [8:0] expv(input logic [3:0] g, input logic [1:0] s,
                                        input logic v, input logic bl);
        return {g, s, v, bl};
    endfunction

    task automatic test_reset();
        logic [8:0] o;
        logic [8:0] e;
        rst_n = 1'b0;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            o = obs(k == 0 ? 4 : k);
            vectors++;
            if (o !== 9'd0) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: got %b want %b", k, o, 9'd0);
            end
        end
        rst_n = 1'b1;
        b4.req = 4'b0001;
        step();
        o = obs(4);
        e = expv(4'b0001, 2'b00, 1'b1, 1'b0);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL reset_pre_grant: got %b want %b", o, e);
        end
        rst_n = 1'b0;
        step();
        o = obs(4);
        vectors++;
        if (o !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_mid_grant: got %b want %b", o, 9'd0);
        end
        vectors++;
        if (u4.ptr_q !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_ptr: got %0d want 0", u4.ptr_q);
        end
        rst_n = 1'b1;
        b4.req = 4'b0000;
        step();
    endtask

    task automatic test_single();
        logic [8:0] o;
        logic [8:0] e;
        b4.req = 4'b0100;
        b4.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            o = obs(4);
            e = expv(4'b0100, 2'b10, 1'b1, (i % 4) == 3);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL single_cycle%0d: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_idle_return();
        logic [8:0] o;
        logic [8:0] e;
        b4.req = 4'b0000;
        #1;
        o = obs(4);
        e = expv(4'b0100, 2'b10, 1'b1, 1'b1);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL idle_last_on_drop: got %b want %b", o, e);
        end
        step();
        o = obs(4);
        e = expv(4'b0000, 2'b10, 1'b0, 1'b0);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL idle_return: got %b want %b", o, e);
        end
        vectors++;
        if (u4.ptr_q !== 2'd3) begin
            miscompares++;
            $display("FAIL idle_ptr: got %0d want 3", u4.ptr_q);
        end
        b4.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [8:0] o;
        logic [8:0] e;
        b4.req = 4'b0011;
        b4.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            o = obs(4);
            e = expv(4'b0001, 2'b00, 1'b1, i >= 2);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL backpressure_hold%0d: got %b want %b", i, o, e);
            end
            if (i == 1) b4.req = 4'b0010;
        end
        b4.out_ready = 1'b1;
        step();
        o = obs(4);
        e = expv(4'b0010, 2'b01, 1'b1, 1'b0);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL backpressure_handoff: got %b want %b", o, e);
        end
        b4.out_ready = 1'b0;
        b4.req = 4'b0000;
    endtask

    task automatic test_all_request();
        logic [8:0] o;
        logic [8:0] e;
        b1.req = 4'b1111;
        b1.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            o = obs(1);
            e = expv(4'b0001 << (i % 4), 2'(i % 4), 1'b1, 1'b1);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL all_rr_cycle%0d: got %b want %b", i, o, e);
            end
        end
        b1.req = 4'b0000;
        b1.out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [8:0] o;
        logic [8:0] e;
        logic [8:0] exp_tab [5];
        exp_tab[0] = expv(4'b1000, 2'b11, 1'b1, 1'b0);
        exp_tab[1] = expv(4'b1000, 2'b11, 1'b1, 1'b1);
        exp_tab[2] = expv(4'b0001, 2'b00, 1'b1, 1'b0);
        exp_tab[3] = expv(4'b0001, 2'b00, 1'b1, 1'b1);
        exp_tab[4] = expv(4'b1000, 2'b11, 1'b1, 1'b0);
        b2.req = 4'b1000;
        b2.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            o = obs(2);
            e = exp_tab[i];
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL wrap_cycle%0d: got %b want %b", i, o, e);
            end
            if (i == 1) b2.req = 4'b1001;
            if (i == 2) begin
                vectors++;
                if (u2.ptr_q !== 2'd0) begin
                    miscompares++;
                    $display("FAIL wrap_ptr_zero: got %0d want 0", u2.ptr_q);
                end
            end
        end
        vectors++;
        if (u2.ptr_q !== 2'd1) begin
            miscompares++;
            $display("FAIL wrap_ptr_after_a: got %0d want 1", u2.ptr_q);
        end
        b2.req = 4'b0000;
        b2.out_ready = 1'b0;
    endtask

    initial begin
        b4.req = '0;
        b4.out_ready = 1'b0;
        b1.req = '0;
        b1.out_ready = 1'b0;
        b2.req = '0;
        b2.out_ready = 1'b0;
        test_reset();
        test_single();
        test_idle_return();
        test_backpressure();
        test_all_request();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
